// File: rtl/mem_pkg.sv
// Shared types and constants for the main-memory responder.
// A word is four bytes with byte [0] as the most significant lane.
package mem_pkg;

   typedef logic [7:0] byte_t;
   typedef byte_t [0:3] word_t;

   typedef enum logic {
      IDLE,
      WAIT
   } state_e;

   localparam int unsigned DefaultLatency = 4;
   localparam int unsigned CntBits        = 8;

endpackage

// File: rtl/main_memory_responder_if.sv
// Cache-to-memory request/response bundle.
// The cache side is the master; the memory responder is the slave.
interface main_memory_responder_if;
   import mem_pkg::*;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   word_t       mem_data_in;
   word_t       mem_data_out;
   logic        mem_ready;
   logic        mem_busy;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_data_in,
      input  mem_data_out,
      input  mem_ready,
      input  mem_busy
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_data_in,
      output mem_data_out,
      output mem_ready,
      output mem_busy
   );

endinterface

// File: rtl/memory_array.sv
// Word-indexed storage built from four byte lanes.
// Writes are synchronous to clk_i; reads are combinational. Contents are never reset.
module memory_array
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_BITS = 16
) (
   input  logic                 clk_i,
   input  logic                 we_i,
   input  logic [ADDR_BITS-3:0] idx_i,
   input  word_t                wdata_i,
   output word_t                rdata_o
);

   localparam int unsigned Words = 2 ** (ADDR_BITS - 2);

   for (genvar l = 0; l < 4; l++) begin : g_lane
      byte_t lane_q [Words];

      always_ff @(posedge clk_i) begin
         if (we_i) begin
            lane_q[idx_i] <= wdata_i[l];
         end
      end

      assign rdata_o[l] = lane_q[idx_i];
   end

endmodule

// File: rtl/main_memory_responder.sv
// Main-memory responder: accepts one request at a time and completes it
// LATENCY cycles later with a one-cycle mem_ready pulse.
module main_memory_responder
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_BITS = 16,
   parameter int unsigned LATENCY   = DefaultLatency
) (
   input logic                     clk,
   input logic                     rst_b,
   main_memory_responder_if.slave  bus
);

   localparam int unsigned IdxBits = ADDR_BITS - 2;

   state_e               state_q, state_d;
   logic [CntBits-1:0]   cnt_q, cnt_d;
   logic [IdxBits-1:0]   idx_q, idx_d;
   logic                 we_q, we_d;
   word_t                wdata_q, wdata_d;
   word_t                dout_q, dout_d;
   logic                 busy_q, busy_d;
   logic                 ready_q, ready_d;

   logic                 commit;
   logic                 arr_we;
   word_t                arr_rdata;

   // Byte-offset and high address bits are don't-care (high bits alias).
   logic unused_addr;
   assign unused_addr = ^{bus.mem_addr[31:ADDR_BITS], bus.mem_addr[1:0]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      dout_d  = dout_q;
      busy_d  = busy_q;
      ready_d = 1'b0;
      commit  = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.mem_req) begin
               idx_d   = bus.mem_addr[ADDR_BITS-1:2];
               we_d    = bus.mem_we;
               wdata_d = bus.mem_data_in;
               cnt_d   = CntBits'(LATENCY - 1);
               busy_d  = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               commit  = 1'b1;
               if (!we_q) begin
                  dout_d = arr_rdata;
               end
               ready_d = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         dout_q  <= '0;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         dout_q  <= dout_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
      end
   end

   // Write lands on the completion edge only, so a reset during WAIT discards it.
   assign arr_we = commit & we_q;

   memory_array #(
      .ADDR_BITS (ADDR_BITS)
   ) u_array (
      .clk_i   (clk),
      .we_i    (arr_we),
      .idx_i   (idx_q),
      .wdata_i (wdata_q),
      .rdata_o (arr_rdata)
   );

   assign bus.mem_data_out = dout_q;
   assign bus.mem_ready    = ready_q;
   assign bus.mem_busy     = busy_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench for main_memory_responder: a LATENCY=4 instance for the
// transaction table and corner cases, and a LATENCY=1 instance for back-to-back.
module tb_main_memory_responder;
   import mem_pkg::*;

   logic clk   = 1'b0;
   logic rst_b = 1'b0;
   always #5 clk = ~clk;

   main_memory_responder_if a_if ();
   main_memory_responder_if b_if ();

   main_memory_responder #(
      .ADDR_BITS (16),
      .LATENCY   (4)
   ) dut_a (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (a_if.slave)
   );

   main_memory_responder #(
      .ADDR_BITS (16),
      .LATENCY   (1)
   ) dut_b (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (b_if.slave)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t        vecs [8];
   int          errors = 0;
   int          checks = 0;
   int          lat;
   int          pulses;
   logic [31:0] rd;
   logic [31:0] last_rd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One request on dut_a; lat = edges from acceptance to mem_ready, -1 on timeout.
   task automatic access_a(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rdata, output int lat_o);
      @(negedge clk);
      a_if.mem_req     = 1'b1;
      a_if.mem_we      = we;
      a_if.mem_addr    = addr;
      a_if.mem_data_in = wd;
      @(posedge clk);
      #1;
      a_if.mem_req = 1'b0;
      lat_o = -1;
      rdata = '0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (a_if.mem_ready) begin
            lat_o = i;
            rdata = a_if.mem_data_out;
            break;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0};
      vecs[1] = '{1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF};
      vecs[2] = '{1'b1, 32'h0001_0040, 32'h1122_3344, 32'h0};
      vecs[3] = '{1'b0, 32'h0000_0043, 32'h0,         32'h1122_3344};
      vecs[4] = '{1'b1, 32'h0000_0080, 32'h0102_0304, 32'h0};
      vecs[5] = '{1'b0, 32'h0000_0080, 32'h0,         32'h0102_0304};
      vecs[6] = '{1'b1, 32'h0000_0100, 32'hA0B0_C0D0, 32'h0};
      vecs[7] = '{1'b0, 32'h0000_0100, 32'h0,         32'hA0B0_C0D0};

      a_if.mem_req = 1'b0; a_if.mem_we = 1'b0; a_if.mem_addr = '0; a_if.mem_data_in = '0;
      b_if.mem_req = 1'b0; b_if.mem_we = 1'b0; b_if.mem_addr = '0; b_if.mem_data_in = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_b = 1'b1;

      // Reset in the middle of an in-flight write
      @(negedge clk);
      a_if.mem_req = 1'b1; a_if.mem_we = 1'b1;
      a_if.mem_addr = 32'h40; a_if.mem_data_in = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      a_if.mem_req = 1'b0;
      @(negedge clk);
      rst_b = 1'b0;
      repeat (2) @(negedge clk);
      rst_b = 1'b1;
      chk("rst_busy", 32'(a_if.mem_busy), 32'd0);
      chk("rst_ready", 32'(a_if.mem_ready), 32'd0);
      chk("rst_data", a_if.mem_data_out, 32'h0);
      pulses = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (a_if.mem_ready) pulses++;
      end
      chk("idle_pulses", pulses, 0);

      last_rd = 32'h0;
      for (int v = 0; v < 8; v++) begin
         access_a(vecs[v].we, vecs[v].addr, vecs[v].wdata, rd, lat);
         chk($sformatf("vec%0d_latency", v), lat, 4);
         if (vecs[v].we) begin
            chk($sformatf("vec%0d_wr_dout", v), rd, last_rd);
         end else begin
            chk($sformatf("vec%0d_rd_data", v), rd, vecs[v].exp);
            last_rd = vecs[v].exp;
         end
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_ready_fall", v), 32'(a_if.mem_ready), 32'd0);
         chk($sformatf("vec%0d_dout_hold", v), a_if.mem_data_out, last_rd);
      end

      // Write issued while a read is in flight must be dropped
      @(negedge clk);
      a_if.mem_req = 1'b1; a_if.mem_we = 1'b0; a_if.mem_addr = 32'h80;
      @(posedge clk);
      #1;
      a_if.mem_req = 1'b0;
      pulses = 0;
      rd = '0;
      for (int c = 1; c <= 14; c++) begin
         @(posedge clk);
         #1;
         if (c == 1) begin
            chk("drop_busy", 32'(a_if.mem_busy), 32'd1);
            a_if.mem_req = 1'b1; a_if.mem_we = 1'b1; a_if.mem_data_in = 32'hCAFE_F00D;
         end
         if (c == 2) a_if.mem_req = 1'b0;
         if (a_if.mem_ready) begin
            pulses++;
            rd = a_if.mem_data_out;
         end
      end
      chk("drop_pulses", pulses, 1);
      chk("drop_rd_data", rd, 32'h0102_0304);
      access_a(1'b0, 32'h80, 32'h0, rd, lat);
      chk("drop_old_data", rd, 32'h0102_0304);

      // Reset at cnt=1 during a write: no pulse, no commit
      @(negedge clk);
      a_if.mem_req = 1'b1; a_if.mem_we = 1'b1;
      a_if.mem_addr = 32'h100; a_if.mem_data_in = 32'h55AA_55AA;
      @(posedge clk);
      #1;
      a_if.mem_req = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_b = 1'b0;
      pulses = 0;
      repeat (2) begin
         @(posedge clk);
         #1;
         if (a_if.mem_ready) pulses++;
      end
      @(negedge clk);
      rst_b = 1'b1;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (a_if.mem_ready) pulses++;
      end
      chk("rstw_pulses", pulses, 0);
      chk("rstw_busy", 32'(a_if.mem_busy), 32'd0);
      access_a(1'b0, 32'h100, 32'h0, rd, lat);
      chk("rstw_old_data", rd, 32'hA0B0_C0D0);

      // LATENCY=1 back-to-back writes with mem_req held for 6 edges
      @(negedge clk);
      b_if.mem_req = 1'b1; b_if.mem_we = 1'b1;
      b_if.mem_addr = 32'h20; b_if.mem_data_in = 32'h1234_5678;
      pulses = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         #1;
         if (c == 5) b_if.mem_req = 1'b0;
         if (b_if.mem_ready) begin
            pulses++;
            chk($sformatf("b2b_phase_c%0d", c), 32'(c % 2), 32'd1);
         end
      end
      chk("b2b_pulses", pulses, 3);

      @(negedge clk);
      b_if.mem_req = 1'b1; b_if.mem_we = 1'b0; b_if.mem_addr = 32'h20;
      @(posedge clk);
      #1;
      b_if.mem_req = 1'b0;
      lat = -1;
      rd = '0;
      for (int i = 1; i <= 5; i++) begin
         @(posedge clk);
         #1;
         if (b_if.mem_ready) begin
            lat = i;
            rd = b_if.mem_data_out;
            break;
         end
      end
      chk("b_latency", lat, 1);
      chk("b_rd_data", rd, 32'h1234_5678);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
